stream_mux: RTL and testbench
=============================

# stream_mux

Parametrised, registered N-to-1 stream multiplexer with valid/ready handshakes on every input channel and on the output. It generalises the team's 4:1 single-bit combinational multiplexer to CHANNELS inputs of WIDTH bits. It offers two selection modes: addressed, where the channel is chosen by `addr`, and round-robin, where channels are served fairly. It sits between several producer streams and one shared consumer, for example a shared bus or serializer front end.

## Interface
Parameters:
- `WIDTH`, default 8: data bits per channel.
- `CHANNELS`, default 4: number of input channels, 2..16; need not be a power of two.
- `ADDR_W`, default 2: select/channel-id width; must be at least ceil(log2(CHANNELS)).

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `mode`, input, 1: 0 = addressed, 1 = round-robin.
- `addr`, input, ADDR_W: channel select, used in addressed mode only.
- `in_data`, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`, input, CHANNELS: per-channel valid.
- `in_ready`, output, CHANNELS: per-channel ready, combinational.
- `out_data`, output, WIDTH: registered output word.
- `out_chan`, output, ADDR_W: registered index of the source channel of `out_data`.
- `out_valid`, output, 1: registered output valid.
- `out_ready`, input, 1: consumer ready.

## Operation
Load enable:
- `load_en = !out_valid || out_ready`.

Channel selection (combinational, every cycle):
- Addressed mode: `sel = addr` and `sel_ok = (addr < CHANNELS)`. `in_valid` does not affect `sel`.
- Round-robin mode: `sel` is the first channel i with `in_valid[i]` = 1, scanning `ptr`, `ptr+1`, …, wrapping past CHANNELS-1 to 0. `sel_ok` = 1 if any `in_valid` is 1, otherwise 0.

Ready generation:
- `in_ready[i] = load_en && sel_ok && (i == sel)`.
- At most one `in_ready` bit is high in any cycle.
- `in_ready` must never depend on `in_valid[sel]` in addressed mode. It depends on `in_valid` in round-robin mode only through arbitration.

Input transfer:
- Occurs on channel `sel` when `in_valid[sel] && in_ready[sel]`.
- On the edge, `out_data <= in_data[sel]`, `out_chan <= sel`, `out_valid <= 1`.

Output transfer:
- Occurs when `out_valid && out_ready`.
- If no input transfer happens on the same edge, `out_valid <= 0`.
- `out_data` and `out_chan` hold their last values.

Stall:
- While `out_valid && !out_ready`, `out_data`, `out_chan` and `out_valid` hold, and all `in_ready` bits are 0.

Round-robin pointer `ptr` (ADDR_W bits):
- Updates only on an input transfer while `mode` = 1: `ptr <= (sel == CHANNELS-1) ? 0 : sel + 1`.
- Holds in addressed mode and on cycles without a transfer.

Mode and address changes:
- Take effect in the same cycle.
- Never alter a word already held in the output register.

## Timing
- Reset values (on the clock edge with `reset` = 1): `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `ptr` = 0. `in_ready` is forced to all-0 while `reset` is high.
- Latency: one cycle from an input transfer to `out_valid` = 1 carrying that word.
- Throughput: one word per cycle when `out_ready` is held high; the output register refills on the same edge it drains.
- Simultaneous drain and fill: the new word replaces the old one and `out_valid` stays 1.
- Reset mid-operation: a held output word is discarded and not presented again. `ptr` returns to 0. Inputs see `in_ready` = 0 during reset, so no transfer is accepted.
- Addressed mode with `addr >= CHANNELS`: no channel is ready, the output drains normally, and no error is flagged.
- Round-robin wrap: with `ptr = CHANNELS-1` and only channel 0 valid, channel 0 is granted and `ptr` becomes 1.
- No combinational path from `out_ready` to `out_data` or `out_valid`. The path from `out_ready` to `in_ready` is permitted.

## Test plan
1. Reset, then addressed mode: `addr` = 2, `in_valid` = 4'b0100, `in_data[2]` = 8'hA5, `out_ready` = 1. Required: `in_ready` = 4'b0100, and one cycle later `out_data` = A5, `out_chan` = 2, `out_valid` = 1. Repeat for every channel, mirroring the 4:1 truth-table sweep.
2. Round-robin, all four channels valid continuously with `out_ready` = 1. Required: `out_chan` sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
3. Back-pressure: `out_ready` = 0 for 3 cycles after `out_valid` rises. Required: `out_data` and `out_chan` are stable, `in_ready` = 0, no input word is lost or duplicated, and flow resumes in the cycle `out_ready` returns to 1.
4. CHANNELS = 3 instance: addressed mode with `addr` = 3 and all valid. Required: `in_ready` = 0 and `out_valid` falls after draining. Round-robin with `ptr` = 2 and only channel 0 valid. Required: grant to 0, then `ptr` = 1.
5. Reset asserted while `out_valid` = 1 and `out_ready` = 0. Required: next cycle `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `in_ready` = 0 during reset. After release in round-robin mode with all channels valid, the first grant is to channel 0.
6. Switch `mode` 1→0 mid-stream with `addr` = 1. Required: the next transfer comes from channel 1, and `ptr` is unchanged when switching back to mode 1.

Source files
------------

// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux
//  Description : Registered N-to-1 stream multiplexer with valid/ready
//                handshakes per input channel and on the output. Supports
//                addressed selection (channel chosen by addr) and fair
//                round-robin selection starting at a rotating pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [ADDR_W-1:0]         out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Channel count widened by one bit so addr values >= CHANNELS compare cleanly.
  localparam logic [ADDR_W:0]   C_CHANNELS  = (ADDR_W+1)'(CHANNELS);
  localparam logic [ADDR_W-1:0] C_LAST_CHAN = ADDR_W'(CHANNELS-1);
  localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);
  localparam logic              C_MODE_RR   = 1'b1;

  // Output register and round-robin pointer
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_chan_q,  out_chan_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;

  // Selection and handshake wires
  logic              w_load_en;
  logic [ADDR_W-1:0] w_addr_sel;
  logic              w_addr_ok;
  logic [ADDR_W-1:0] w_rr_hi_sel;
  logic              w_rr_hi_ok;
  logic [ADDR_W-1:0] w_rr_any_sel;
  logic              w_rr_any_ok;
  logic [ADDR_W-1:0] w_sel;
  logic              w_sel_ok;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_sel_valid;
  logic              w_in_xfer;

  // The output register may accept a new word when empty or draining this cycle.
  always_comb begin
    w_load_en = !out_valid_q || out_ready;
  end

  // Addressed selection: any out-of-range address simply selects nothing.
  always_comb begin
    w_addr_sel = addr;
    w_addr_ok  = ({1'b0, addr} < C_CHANNELS);
  end

  // Round-robin scan split in two priority passes: the lowest valid channel at
  // or above ptr wins; if none exists, the lowest valid channel overall (wrap).
  // Scanning downward lets the lowest index overwrite earlier hits.
  always_comb begin
    w_rr_hi_sel  = ptr_q;
    w_rr_hi_ok   = 1'b0;
    w_rr_any_sel = ptr_q;
    w_rr_any_ok  = 1'b0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_rr_any_sel = ADDR_W'(i);
        w_rr_any_ok  = 1'b1;
        if (ADDR_W'(i) >= ptr_q) begin
          w_rr_hi_sel = ADDR_W'(i);
          w_rr_hi_ok  = 1'b1;
        end
      end
    end
  end

  // Final channel choice according to the current mode.
  always_comb begin
    w_sel    = w_addr_sel;
    w_sel_ok = w_addr_ok;
    if (mode == C_MODE_RR) begin
      w_sel    = w_rr_hi_ok ? w_rr_hi_sel : w_rr_any_sel;
      w_sel_ok = w_rr_any_ok;
    end
  end

  // Pick the selected channel's data and valid; out-of-range selects give zeros.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_sel == ADDR_W'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        w_sel_valid = in_valid[i];
      end
    end
  end

  // One-hot ready toward the chosen channel, suppressed during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !reset && w_load_en && w_sel_ok && (w_sel == ADDR_W'(i));
    end
  end

  // Input transfer happens on the selected channel when both sides agree.
  always_comb begin
    w_in_xfer = !reset && w_load_en && w_sel_ok && w_sel_valid;
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (w_in_xfer) begin
      out_data_d  = w_sel_data;
      out_chan_d  = w_sel;
      out_valid_d = 1'b1;
      if (mode == C_MODE_RR) begin
        ptr_d = (w_sel == C_LAST_CHAN) ? '0 : w_sel + C_ONE;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a held word is discarded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mux
//  Description : Scoreboard bench for stream_mux. A 4-channel instance runs
//                directed scenarios and randomized traffic against a
//                behavioural model; a 3-channel instance covers the
//                non-power-of-two address range and round-robin wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        reset, mode, out_ready, out_valid;
  logic [1:0]  addr, out_chan;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;

  // 3-channel instance
  logic        b_reset, b_mode, b_out_ready, b_out_valid;
  logic [1:0]  b_addr, b_out_chan;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;

  stream_mux #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2)) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .addr(addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux #(.WIDTH(8), .CHANNELS(3), .ADDR_W(2)) u_dut3 (
    .clk(clk), .reset(b_reset), .mode(b_mode), .addr(b_addr),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state (4-channel instance)
  logic       model_on  = 1'b0;
  logic       after_rst = 1'b0;
  logic       m_valid   = 1'b0;
  int         m_ptr     = 0;
  int         m_g;
  logic       m_ld;
  logic [3:0] m_exp_rdy;
  logic [3:0] acc = 4'd0;
  logic [9:0] exp_q[$];
  logic [9:0] m_word;

  logic [7:0] t1d [4] = '{8'h3C, 8'h5A, 8'hA5, 8'hD3};
  logic [7:0] hold_d;
  logic [1:0] hold_c;
  int         sp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: decide from the rules which channel should be ready this cycle,
  // and queue the word that must appear at the output after the edge.
  always @(negedge clk) begin
    if (model_on) begin
      #1;
      if (reset) begin
        check("in_ready_during_reset", 32'(in_ready), 32'd0);
        m_valid   = 1'b0;
        m_ptr     = 0;
        after_rst = 1'b1;
        exp_q.delete();
      end else begin
        after_rst = 1'b0;
        m_ld = !m_valid || out_ready;
        m_g  = -1;
        if (!mode) begin
          if (int'(addr) < 4) m_g = int'(addr);
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (m_g < 0 && in_valid[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
          end
        end
        m_exp_rdy = (m_ld && m_g >= 0) ? 4'(1 << m_g) : 4'd0;
        check("in_ready", 32'(in_ready), 32'(m_exp_rdy));
        if (m_exp_rdy != 4'd0 && in_valid[m_g]) begin
          exp_q.push_back({2'(m_g), in_data[m_g*8 +: 8]});
          m_valid = 1'b1;
          acc[m_g] = 1'b1;
          if (mode) m_ptr = (m_g + 1) % 4;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: compare out_valid every cycle and pop/compare each drained word.
  always @(negedge clk) begin
    if (model_on) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (after_rst) begin
        check("out_data_after_reset", 32'(out_data), 32'd0);
        check("out_chan_after_reset", 32'(out_chan), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_word: got chan %0d data 0x%02h, expected no word", out_chan, out_data);
        end else begin
          m_word = exp_q.pop_front();
          check("out_word", 32'({out_chan, out_data}), 32'(m_word));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; mode = 1'b0; addr = 2'd0; in_data = 32'd0; in_valid = 4'd0; out_ready = 1'b0;
    b_reset = 1'b1; b_mode = 1'b0; b_addr = 2'd1; b_in_valid = 3'd0; b_out_ready = 1'b1;
    b_in_data = {8'h12, 8'h11, 8'h10};
    @(posedge clk);
    #1 model_on = 1'b1;
    step();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_chan", 32'(out_chan), 32'd0);
    reset = 1'b0;

    // Addressed sweep over every channel
    out_ready = 1'b1;
    mode = 1'b0;
    in_data = {t1d[3], t1d[2], t1d[1], t1d[0]};
    for (int c = 0; c < 4; c++) begin
      addr = 2'(c);
      in_valid = 4'(1 << c);
      #1 check("addr_in_ready", 32'(in_ready), 32'(1 << c));
      step();
      in_valid = 4'd0;
      #1;
      check("addr_out_data", 32'(out_data), 32'(t1d[c]));
      check("addr_out_chan", 32'(out_chan), 32'(c));
      check("addr_out_valid", 32'(out_valid), 32'd1);
      step();
    end

    // Round-robin, all channels valid, no bubbles
    mode = 1'b1;
    in_valid = 4'hF;
    step();
    for (int k = 0; k < 6; k++) begin
      check("rr_out_chan", 32'(out_chan), 32'(k % 4));
      check("rr_out_valid", 32'(out_valid), 32'd1);
      in_data = $urandom;
      step();
    end

    // Back-pressure for three cycles
    out_ready = 1'b0;
    hold_d = out_data;
    hold_c = out_chan;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_in_ready", 32'(in_ready), 32'd0);
      step();
      check("stall_out_data", 32'(out_data), 32'(hold_d));
      check("stall_out_chan", 32'(out_chan), 32'(hold_c));
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("resume_in_ready", 32'(in_ready), 32'h8);
    step();
    check("resume_out_chan", 32'(out_chan), 32'd3);

    // Reset while a word is held under back-pressure
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_chan", 32'(out_chan), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    mode = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    step();
    check("post_reset_first_grant", 32'(out_chan), 32'd0);

    // Mode switch mid-stream; pointer must survive addressed transfers
    step();
    mode = 1'b0;
    addr = 2'd1;
    sp = m_ptr;
    step();
    check("switch_addr_chan", 32'(out_chan), 32'd1);
    step();
    check("switch_addr_chan2", 32'(out_chan), 32'd1);
    mode = 1'b1;
    step();
    check("switch_back_ptr", 32'(out_chan), 32'(sp));

    // 3-channel instance: out-of-range address and round-robin wrap
    b_reset = 1'b0;
    b_in_valid = 3'b111;
    step();
    check("c3_load_valid", 32'(b_out_valid), 32'd1);
    check("c3_load_chan", 32'(b_out_chan), 32'd1);
    b_addr = 2'd3;
    #1 check("c3_addr3_in_ready", 32'(b_in_ready), 32'd0);
    step();
    check("c3_drain_valid", 32'(b_out_valid), 32'd0);
    step();
    check("c3_idle_valid", 32'(b_out_valid), 32'd0);
    b_mode = 1'b1;
    b_in_valid = 3'b010;
    step();
    check("c3_rr_chan1", 32'(b_out_chan), 32'd1);
    b_in_valid = 3'b001;
    #1 check("c3_wrap_in_ready", 32'(b_in_ready), 32'b001);
    step();
    check("c3_wrap_chan", 32'(b_out_chan), 32'd0);
    check("c3_wrap_data", 32'(b_out_data), 32'h10);
    b_in_valid = 3'b111;
    #1 check("c3_ptr_after_wrap", 32'(b_in_ready), 32'b010);

    // Randomized traffic on the 4-channel instance
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 4) == 0) addr = 2'($urandom);
      for (int c = 0; c < 4; c++) begin
        if (acc[c] || !in_valid[c]) begin
          in_valid[c] = 1'($urandom_range(0, 1));
          in_data[c*8 +: 8] = 8'($urandom);
        end
      end
      acc = 4'd0;
      step();
    end
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
